// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op/state encodings and constants for the multiply/divide unit
package muldiv_pkg;
  localparam int ITER_COUNT = 32;
  typedef enum logic [2:0] {
    OP_MULTU = 3'b000,
    OP_MULT  = 3'b001,
    OP_DIVU  = 3'b010,
    OP_DIV   = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101,
    OP_NOP0  = 3'b110,
    OP_NOP1  = 3'b111
  } op_t;
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;
  function automatic logic [31:0] mag(input logic [31:0] v, input logic s);
    return s ? -v : v;
  endfunction
endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 32-bit shift-add multiplier and restoring divider with HI/LO
module muldiv_unit
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  state_t state, state_nx;
  op_t opc;
  logic [4:0] cnt;
  logic [63:0] acc, prod;
  logic [31:0] opb, quo, rem;
  logic [32:0] add_x, add_y, sum;
  logic is_div, sgn, sa, sb, last, neg, dz, go, sa_n, sb_n;
  assign opc = op_t'(op);
  assign last = cnt == 5'(ITER_COUNT - 1);
  assign go = start && state == S_IDLE;
  assign sa_n = op[0] & a[31];
  assign sb_n = op[0] & b[31];
  assign neg = sgn & (sa ^ sb);
  assign dz = opb == 32'd0;
  assign prod = neg ? -acc : acc;
  assign quo = (neg && !dz) ? -acc[31:0] : acc[31:0];
  assign rem = sa ? -acc[63:32] : acc[63:32];
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (start) state_nx = (opc == OP_MULTU || opc == OP_MULT) ? S_MUL :
                                    (opc == OP_DIVU || opc == OP_DIV) ? S_DIV : S_IDLE;
      S_MUL, S_DIV: if (last) state_nx = S_FIX;
      default: state_nx = S_IDLE;
    endcase
  end
  always_comb begin
    busy = state != S_IDLE;
  end
  // One adder: multiply adds the multiplicand, divide subtracts the divisor from the shifted remainder
  always_comb begin
    add_x = is_div ? acc[63:31] : {1'b0, acc[63:32]};
    add_y = is_div ? ~{1'b0, opb} : {1'b0, acc[0] ? opb : 32'd0};
    sum = add_x + add_y + {32'd0, is_div};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      acc <= '0;
      opb <= '0;
      is_div <= 1'b0;
      sgn <= 1'b0;
      sa <= 1'b0;
      sb <= 1'b0;
      hi <= '0;
      lo <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (go) begin
        if (opc == OP_MTHI) hi <= a;
        if (opc == OP_MTLO) lo <= a;
        if (!op[2]) begin
          sgn <= op[0];
          sa <= sa_n;
          sb <= sb_n;
          is_div <= op[1];
          cnt <= '0;
          acc <= {32'd0, op[1] ? mag(a, sa_n) : mag(b, sb_n)};
          opb <= op[1] ? mag(b, sb_n) : mag(a, sa_n);
        end
      end else if (state == S_MUL || state == S_DIV) begin
        cnt <= cnt + 5'd1;
        acc <= is_div ? {sum[32] ? acc[62:31] : sum[31:0], acc[30:0], ~sum[32]} : {sum, acc[31:1]};
      end else if (state == S_FIX) begin
        done <= 1'b1;
        hi <= is_div ? rem : prod[63:32];
        lo <= is_div ? quo : prod[31:0];
      end
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: table-driven and scoreboarded checks of muldiv_unit
module tb_muldiv_unit;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [2:0] op = 3'b000;
  logic [31:0] a = '0, b = '0;
  logic busy, done;
  logic [31:0] hi, lo;
  int tests = 0, fails = 0;
  typedef struct { logic [31:0] h, l; } res_t;
  typedef struct { logic [2:0] op; logic [31:0] a, b, h, l; } vec_t;
  res_t sbq[$];
  vec_t vt[13];
  muldiv_unit dut (.clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
                   .busy(busy), .done(done), .hi(hi), .lo(lo));
  always #5 clk = ~clk;
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic res_t model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] p;
    logic [31:0] q, r;
    res_t e;
    case (o)
      3'b000: p = {32'd0, x} * {32'd0, y};
      3'b001: p = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
      3'b010: p = (y == 0) ? {x, 32'hFFFFFFFF} : {x % y, x / y};
      default: begin
        if (y == 0) p = {x, 32'hFFFFFFFF};
        else if (x == 32'h80000000 && y == 32'hFFFFFFFF) p = {32'd0, 32'h80000000};
        else begin
          q = $signed(x) / $signed(y);
          r = $signed(x) % $signed(y);
          p = {r, q};
        end
      end
    endcase
    e.h = p[63:32];
    e.l = p[31:0];
    return e;
  endfunction
  task automatic run_op(input string nm, input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, input res_t e);
    int k, bad;
    logic [31:0] h0, l0;
    res_t r;
    h0 = hi;
    l0 = lo;
    bad = 0;
    sbq.push_back(e);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom;
    k = 0;
    while (done !== 1'b1 && k < 40) begin
      if (busy !== 1'b1 || hi !== h0 || lo !== l0) bad++;
      @(negedge clk);
      k++;
    end
    check({nm, " latency"}, 32'(k), 32'd33);
    check({nm, " busy at done"}, 32'(busy), 32'd0);
    check({nm, " hold while busy"}, 32'(bad), 32'd0);
    r = sbq.pop_front();
    check({nm, " hi"}, hi, r.h);
    check({nm, " lo"}, lo, r.l);
    @(negedge clk);
    check({nm, " done single"}, 32'(done), 32'd0);
  endtask
  task automatic mt_op(input string nm, input logic [2:0] o, input logic [31:0] x);
    logic [31:0] h0, l0;
    int seen;
    h0 = hi;
    l0 = lo;
    @(negedge clk);
    start = 1'b1; op = o; a = x;
    @(negedge clk);
    start = 1'b0;
    seen = int'(busy) + int'(done);
    check({nm, " hi"}, hi, o == 3'b100 ? x : h0);
    check({nm, " lo"}, lo, o == 3'b101 ? x : l0);
    repeat (3) begin
      @(negedge clk);
      seen += int'(busy) + int'(done);
    end
    check({nm, " busy/done quiet"}, 32'(seen), 32'd0);
  endtask
  initial begin
    res_t e;
    logic [2:0] ro;
    logic [31:0] rx, ry, h0;
    int seen;
    vt[0]  = '{3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vt[1]  = '{3'b001, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
    vt[2]  = '{3'b011, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vt[3]  = '{3'b010, 32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF};
    vt[4]  = '{3'b011, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vt[5]  = '{3'b010, 32'd100,      32'd7,        32'd2,        32'd14};
    vt[6]  = '{3'b001, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9};
    vt[7]  = '{3'b000, 32'h12345678, 32'h00000100, 32'h00000012, 32'h34567800};
    vt[8]  = '{3'b011, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vt[9]  = '{3'b011, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
    vt[10] = '{3'b001, 32'hFFFFFFFD, 32'hFFFFFFFB, 32'h00000000, 32'h0000000F};
    vt[11] = '{3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vt[12] = '{3'b010, 32'hFFFFFFFF, 32'd10,       32'd5,        32'h19999999};
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset hi", hi, 32'd0);
    check("reset lo", lo, 32'd0);
    mt_op("mthi", 3'b100, 32'h11112222);
    mt_op("mtlo", 3'b101, 32'hCAFEF00D);
    mt_op("nop110", 3'b110, 32'hFFFFFFFF);
    mt_op("nop111", 3'b111, 32'h0BADBEEF);
    for (int i = 0; i < 13; i++) begin
      e.h = vt[i].h;
      e.l = vt[i].l;
      run_op($sformatf("vec%0d", i), vt[i].op, vt[i].a, vt[i].b, e);
    end
    for (int i = 0; i < 8; i++) begin
      ro = 3'(i % 4);
      rx = $urandom;
      ry = $urandom;
      if (ro[1] && ry == 0) ry = 32'd3;
      run_op($sformatf("rnd%0d", i), ro, rx, ry, model(ro, rx, ry));
    end
    mt_op("mthi pre", 3'b100, 32'h0000DEAD);
    mt_op("mtlo pre", 3'b101, 32'h0000BEEF);
    h0 = hi;
    @(negedge clk);
    start = 1'b1; op = 3'b010; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; op = 3'b100; a = 32'h1234;
    @(negedge clk);
    start = 1'b0;
    check("mthi while busy ignored", hi, h0);
    check("still busy", 32'(busy), 32'd1);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort busy", 32'(busy), 32'd0);
    check("abort hi", hi, 32'd0);
    check("abort lo", lo, 32'd0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      seen += int'(done);
    end
    check("no done after abort", 32'(seen), 32'd0);
    check("abort lo held", lo, 32'd0);
    @(negedge clk);
    reset = 1'b1; start = 1'b1; op = 3'b101; a = 32'h55;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    check("reset beats start lo", lo, 32'd0);
    check("reset beats start busy", 32'(busy), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameters: none; the datapath is fixed at 32 bits.
REQ-002 clk  in  1  single clock; all state changes on the rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 start  in  1  request strobe, sampled on the rising clk edge.
REQ-005 op  in  3  operation: 000 MULTU, 001 MULT, 010 DIVU, 011 DIV, 100 MTHI, 101 MTLO, 11x no-op.
REQ-006 a  in  32  rs operand: multiplicand, dividend, or MTHI/MTLO source.
REQ-007 b  in  32  rt operand: multiplier or divisor.
REQ-008 busy  out  1  iterative operation in progress; HI/LO not valid for MFHI/MFLO.
REQ-009 done  out  1  one-cycle pulse; HI/LO updated by a MULT/MULTU/DIV/DIVU.
REQ-010 hi  out  32  architectural HI register, feeding the MFHI path.
REQ-011 lo  out  32  architectural LO register, feeding the MFLO path.

Function
REQ-012 FSM states: IDLE, MUL, DIV, FIX.
- IDLE->MUL: start with op 000/001.
- IDLE->DIV: start with op 010/011.
- MUL/DIV->FIX: after 32 iteration cycles.
- FIX->IDLE: unconditional.
REQ-013 start shall be accepted only in IDLE; start while busy=1 is ignored, including MTHI/MTLO.
REQ-014 On acceptance, the unit latches:
- op signedness;
- operand signs (signed ops only);
- absolute values of a and b for signed ops, raw values for unsigned ops.
REQ-015 MUL: radix-2 shift-add, one multiplier bit per cycle, 64-bit product accumulator, exactly 32 cycles.
REQ-016 DIV: restoring division, one quotient bit per cycle, 33-bit partial remainder, exactly 32 cycles.
REQ-017 FIX is a one-cycle stage:
- Signed product is negated (64-bit two's complement) when the operand signs differ.
- Signed quotient is negated when the operand signs differ.
- Signed remainder takes the sign of the dividend.
- Result: LO = product[31:0] or quotient; HI = product[63:32] or remainder.
REQ-018 Latency: with start accepted at edge E0, busy=1 from E0 through E33. HI/LO update and done=1 occur at edge E33, and busy=0 in that same cycle.
REQ-019 Divide by zero (DIV or DIVU) with b==0: LO=0xFFFFFFFF and HI=a as latched (unmodified); the sign fix-up is bypassed and the latency is unchanged.
REQ-020 DIV of 0x80000000 by 0xFFFFFFFF: LO=0x80000000, HI=0x00000000; no trap.
REQ-021 MTHI/MTLO accepted in IDLE: hi (or lo) takes the value of a at the next edge. busy and done stay 0, and the other register is unchanged.
REQ-022 Ops 11x are accepted and discarded; no state change occurs.
REQ-023 hi/lo hold their values at all times except at the REQ-018 and REQ-021 update edges; intermediate results are never visible on hi/lo.
REQ-024 done is asserted only in the FIX->IDLE transition cycle and never in two consecutive cycles.

Reset
REQ-025 While reset=1 at a clock edge, the unit enters IDLE with busy=0, done=0, hi=0, lo=0, and clears all iteration counters and accumulators.
REQ-026 Reset asserted mid-operation aborts the operation; no done pulse and no HI/LO update follow.
REQ-027 reset has priority over start in the same cycle.

Structure
REQ-028 A shared package muldiv_pkg holds:
- the op encoding enum (REQ-005);
- the FSM state enum;
- the constant ITER_COUNT=32.
REQ-029 No sub-module; the multiply and divide datapaths share one 64-bit accumulator, one counter and one 33-bit adder/subtractor inside muldiv_unit.
REQ-030 The expected RTL size is 150-300 lines; no combinational multiply or divide operators are used.

Verification
REQ-031 MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> after 33 cycles done=1, HI=0xFFFFFFFE, LO=0x00000001.
REQ-032 MULT a=0xFFFFFFFD (-3), b=0x00000005 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1.
REQ-033 Division cases:
- DIV a=0xFFFFFFF9 (-7), b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU a=7, b=0 -> LO=0xFFFFFFFF, HI=0x00000007.
REQ-034 DIV a=0x80000000, b=0xFFFFFFFF -> LO=0x80000000, HI=0x00000000, done after 33 cycles.
REQ-035 Busy-time and reset behaviour: start DIVU 100/7, then start MTHI a=0x1234 at cycle 5 (ignored), then reset at cycle 10 -> busy=0, hi=lo=0, no done within the next 40 cycles.
REQ-036 MTLO a=0xCAFEF00D in IDLE -> lo=0xCAFEF00D one edge later; busy and done never assert; hi unchanged.
